csa_resolver: RTL and testbench
===============================

# csa_resolver

Iterative carry-propagate resolver for the Booth radix-4 multiplier's Wallace tree. It accepts the final carry-save pair from the 3:2 compressor stage: sum vector `z` and a carry vector `c` that is already shifted left by one. It adds the two vectors one `SEG`-bit segment per cycle and returns the binary product with a carry-out flag. Valid/ready handshakes on both sides let it sit between the tree and the multiplier's result register.

## Interface
- `bits`, default 32: operand width; the data path is `2*bits` wide.
- `SEG`, default 16: segment width added per cycle. `2*bits % SEG` must be 0; otherwise elaboration fails.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `z`/`c` are valid this cycle.
- `in_ready`, output, 1: block can accept a pair.
- `z`, input, `2*bits`: carry-save sum vector.
- `c`, input, `2*bits`: carry-save carry vector, already weighted (shifted).
- `out_valid`, output, 1: `p`/`cout` hold a finished result.
- `out_ready`, input, 1: consumer accepts the result.
- `p`, output, `2*bits`: `(z + c) mod 2^(2*bits)`.
- `cout`, output, 1: carry out of bit `2*bits-1`.

## Operation
- `NSEG = 2*bits/SEG`.
- States:
  - **IDLE**
    - `in_ready=1`.
    - On `in_valid`: capture `z`/`c`, clear the segment index and the carry, go to ADD.
  - **ADD**
    - Each cycle, segment `k` computes `{carry', p[k*SEG +: SEG]} = z_seg + c_seg + carry`.
    - Increment `k`.
    - After segment `NSEG-1`, register `cout` and go to DONE.
  - **DONE**
    - `out_valid=1`; `p`/`cout` stable.
    - On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. Inputs presented in other states are ignored and not captured.
- Inputs are captured into internal registers. `z`/`c` may change freely after acceptance.
- Segments are processed LSB-first. The carry chains across segments exactly as a full-width add; the result is bit-identical to `z + c`.
- `p` bits of segments not yet computed hold 0 during ADD. `p` is cleared on each new accept.
- Reset values: state=IDLE, `in_ready=1`, `out_valid=0`, `p=0`, `cout=0`, index=0, carry=0.
- Reset asserted mid-ADD or in DONE aborts the operation. The result is discarded, and outputs return to reset values immediately (asynchronous).

## Timing
- Accept edge E0, where `in_valid && in_ready`.
- Segments are written at edges E1..E_NSEG.
- `out_valid` rises after E_NSEG, so latency is `NSEG` cycles (4 for the defaults).
- `out_valid` stays high until the edge where `out_ready=1`, then falls. `in_ready` rises on that same edge.
- Minimum initiation interval is `NSEG+2` cycles. There is no accept during DONE, even when `out_ready` is high that cycle.
- `out_ready` is ignored outside DONE.
- `SEG = 2*bits` is legal: single-cycle ADD, latency 1.

## Structure
- Shared multiplier package holds:
  - the state enum (`IDLE`, `ADD`, `DONE`);
  - the `NSEG` computation;
  - the width-check constant.
- One sub-module, `csa_seg_adder`: combinational `SEG`-bit adder with `cin`/`cout`, instantiated once and reused every cycle with a muxed segment select.
- Top level holds the FSM, index counter, carry flop and result register; 120–200 lines.

## Test plan
Defaults `bits=32`, `SEG=16` throughout.
1. Reset then idle.
   - Stimulus: hold reset, then leave `in_valid=0`.
   - Required: `in_ready=1`, `out_valid=0`, `p=0`, `cout=0`.
2. Full ripple.
   - Stimulus: `z=0xFFFF_FFFF_FFFF_FFFF`, `c=0x1`.
   - Required: `p=0`, `cout=1`, `out_valid` exactly 4 cycles after accept.
3. Plain add.
   - Stimulus: `z=0x0000_0001_0000_0000`, `c=0x0000_0000_FFFF_FFFE`.
   - Required: `p=0x0000_0001_FFFF_FFFE`, `cout=0`.
4. Backpressure.
   - Stimulus: hold `out_ready=0` for 10 cycles after `out_valid`; drive a new `in_valid` pair meanwhile.
   - Required: `p`/`cout` stable, `in_ready=0`, new pair not captured. After `out_ready=1`, `in_ready` rises next cycle.
5. Reset mid-ADD.
   - Stimulus: assert `rst_n=0` two cycles after accepting `z=c=0x8000_0000_0000_0000`.
   - Required: outputs immediately at reset values. A following op with `z=2`, `c=3` yields `p=5`, `cout=0`.
6. Random back-to-back ops with random `out_ready`.
   - Stimulus: 1000 random 64-bit `z`/`c` pairs.
   - Required: every `{cout,p}` equals the 65-bit `z+c`, results in order, none dropped or duplicated.

Source files
------------

// File: rtl/csa_resolver_pkg.sv
// Shared definitions for the carry-save resolver: FSM states, segment count
// and the width legality check.
package csa_resolver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nseg(input int width, input int seg);
        return width / seg;
    endfunction

    // Segment width must tile the data path exactly.
    function automatic bit seg_ok(input int width, input int seg);
        return (seg > 0) && (seg <= width) && ((width % seg) == 0);
    endfunction

    function automatic int idx_w(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

endpackage

// File: rtl/csa_seg_adder.sv
// Combinational SEG-bit adder with carry in/out; one slice of the resolver.
module csa_seg_adder #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// Iterative carry-propagate adder that resolves a carry-save pair one
// segment per cycle, LSB first, behind valid/ready handshakes.
module csa_resolver
    import csa_resolver_pkg::*;
#(
    parameter int bits = 32,
    parameter int SEG  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*bits-1:0] z,
    input  logic [2*bits-1:0] c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*bits-1:0] p,
    output logic              cout
);

    localparam int W        = 2 * bits;
    localparam int NSEG     = calc_nseg(W, SEG);
    localparam int IW       = idx_w(NSEG);
    localparam bit WIDTH_OK = seg_ok(W, SEG);

    generate
        if (!WIDTH_OK) begin : g_bad_seg
            $error("csa_resolver: SEG must evenly divide 2*bits");
        end
    endgenerate

    state_t         state, state_nx;
    logic [W-1:0]   z_q, c_q, p_q;
    logic [IW-1:0]  idx;
    logic           carry, cout_q;
    logic [31:0]    base;
    logic [SEG-1:0] z_seg, c_seg, s_seg;
    logic           seg_co;
    logic           last;

    // Segment select by shifting keeps the datapath free of variable part-selects.
    assign base  = 32'(idx) * 32'(SEG);
    assign z_seg = SEG'(z_q >> base);
    assign c_seg = SEG'(c_q >> base);
    assign last  = (idx == IW'(NSEG - 1));

    csa_seg_adder #(.SEG(SEG)) u_seg_adder (
        .a    (z_seg),
        .b    (c_seg),
        .cin  (carry),
        .s    (s_seg),
        .cout (seg_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ADD;
            end
            ADD: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q    <= '0;
            c_q    <= '0;
            p_q    <= '0;
            cout_q <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_q    <= z;
                        c_q    <= c;
                        p_q    <= '0;
                        cout_q <= 1'b0;
                        idx    <= '0;
                        carry  <= 1'b0;
                    end
                end
                ADD: begin
                    // p was cleared on accept and each segment is written once, so OR-in is exact.
                    p_q   <= p_q | (W'(s_seg) << base);
                    carry <= seg_co;
                    idx   <= last ? '0 : idx + IW'(1);
                    if (last) cout_q <= seg_co;
                end
                default: ;
            endcase
        end
    end

    assign p    = p_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: the driver queues the 65-bit sum of each
// accepted pair, a monitor pops and compares on every output handshake.
module tb_csa_resolver;

    localparam int BITS = 32;
    localparam int SEGW = 16;
    localparam int W    = 2 * BITS;
    localparam int NSEG = W / SEGW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] z = '0;
    logic [W-1:0] c = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] p;
    logic         cout;

    always #5 clk = ~clk;

    csa_resolver #(.bits(BITS), .SEG(SEGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .cout      (cout)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          ordy_mode = 0;  // 0: hold low, 1: hold high, 2: random
    logic [64:0] exp_q[$];
    logic        ov_prev = 1'b0;

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (ordy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: latency on every rising out_valid, value on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev)
                chk("latency", 65'(cyc - acc_cyc), 65'(NSEG));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h, nothing outstanding", {cout, p});
                end else begin
                    chk("result", {cout, p}, exp_q.pop_front());
                end
            end
        end
        ov_prev <= out_valid;
    end

    task automatic send(input logic [63:0] zv, input logic [63:0] cv);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        z = zv;
        c = cv;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                acc_cyc = cyc;
                exp_q.push_back(ref_add(zv, cv));
                z = {$urandom, $urandom};
                c = {$urandom, $urandom};
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic wait_ov();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin seen = 1'b1; break; end
        end
        chk("out_valid_timeout", 65'(seen), 65'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 65'(exp_q.size()), 65'd0);
    endtask

    initial begin
        logic [64:0] e;
        logic [63:0] m;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 65'(in_ready), 65'd1);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_p_cout", {cout, p}, 65'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 65'(in_ready), 65'd1);
        chk("idle_out_valid", 65'(out_valid), 65'd0);

        // Full ripple
        ordy_mode = 1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        drain();

        // Plain add, with partial results visible segment by segment
        e = ref_add(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFE);
        send(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFE);
        for (int k = 0; k < NSEG; k++) begin
            @(negedge clk);
            m = (k == 0) ? 64'h0 : ((64'h1 << (SEGW * k)) - 64'h1);
            chk("partial_p", 65'(p), 65'(e[63:0] & m));
        end
        drain();

        // Backpressure with a competing input pair
        ordy_mode = 0;
        e = ref_add(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
        send(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
        wait_ov();
        @(posedge clk); #1;
        in_valid = 1'b1;
        z = 64'h0F0F_0F0F_0F0F_0F0F;
        c = 64'h0101_0101_0101_0101;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 65'(in_ready), 65'd0);
            chk("bp_stable", {cout, p}, e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ordy_mode = 1;
        @(posedge clk); #3;
        ordy_mode = 0;
        chk("bp_in_ready_rise", 65'(in_ready), 65'd1);
        chk("bp_out_valid_fall", 65'(out_valid), 65'd0);
        repeat (8) @(negedge clk);
        chk("bp_no_capture", 65'(out_valid), 65'd0);
        drain();

        // Reset mid-ADD
        ordy_mode = 1;
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 65'(in_ready), 65'd1);
        chk("abort_out_valid", 65'(out_valid), 65'd0);
        chk("abort_p_cout", {cout, p}, 65'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(64'd2, 64'd3);
        drain();

        // Random back-to-back with random consumer stalls
        ordy_mode = 2;
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom}, {$urandom, $urandom});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
